// File: rtl/uart_rx_deserializer.sv
// Purpose: UART receive deserializer, DATA_BITS LSB-first with oversampled mid-bit sampling; optional parity via UART_RX_PARITY_EN.
// Latency: 2 clk synchroniser; valid_o rises 1 clk after the os_tick that samples the stop-bit centre.
// Backpressure: single valid/ready output register; an unconsumed word is overwritten and flagged by a one-clk overrun_o.
module uart_rx_deserializer #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 os_tick,
  input  logic                 rx_i,
  input  logic                 ready_i,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 valid_o,
  output logic                 frame_err_o,
  output logic                 parity_err_o,
  output logic                 overrun_o,
  output logic                 busy_o
);

  localparam int TCW = $clog2(OVERSAMPLE);
  localparam int BCW = $clog2(DATA_BITS);

  localparam logic [TCW-1:0] TICK_HALF_LAST = TCW'(OVERSAMPLE / 2 - 1);
  localparam logic [TCW-1:0] TICK_FULL_LAST = TCW'(OVERSAMPLE - 1);
  localparam logic [BCW-1:0] BIT_LAST       = BCW'(DATA_BITS - 1);

  // Elaboration-time guard against illegal configurations.
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_rx_deserializer: DATA_BITS must be 5..9");
  end
  if (OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0) begin : g_bad_oversample
    $error("uart_rx_deserializer: OVERSAMPLE must be even and >= 4");
  end
  if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity_odd
    $error("uart_rx_deserializer: PARITY_ODD must be 0 or 1");
  end

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START      = 3'd1,
    DATA       = 3'd2,
    PARITY     = 3'd3,
    STOP       = 3'd4,
    BREAK_WAIT = 3'd5
  } state_t;

  state_t                 state;
  logic                   rx_meta;
  logic                   rx_s;
  logic [TCW-1:0]         tick_cnt;
  logic [BCW-1:0]         bit_cnt;
  logic [DATA_BITS-1:0]   shift;
  logic                   bit_end;

`ifdef UART_RX_PARITY_EN
  logic                   par_bit;
`else
  assign parity_err_o = 1'b0;
`endif

  // Full bit period elapsed on this tick (DATA / PARITY / STOP sampling point).
  assign bit_end = (tick_cnt == TICK_FULL_LAST);

  // Two-flop synchroniser; idles high so reset never looks like a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_i;
      rx_s    <= rx_meta;
    end
  end

  // Receive FSM, counters, shift register and the output handshake register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      tick_cnt    <= '0;
      bit_cnt     <= '0;
      shift       <= '0;
      busy_o      <= 1'b0;
      data_o      <= '0;
      valid_o     <= 1'b0;
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit      <= 1'b0;
      parity_err_o <= 1'b0;
`endif
    end else begin
      overrun_o <= 1'b0;
      // Consumer handshake; a load later in this block takes priority.
      if (valid_o && ready_i) begin
        valid_o <= 1'b0;
      end

      if (os_tick) begin
        case (state)
          IDLE: begin
            if (!rx_s) begin
              state    <= START;
              tick_cnt <= '0;
              busy_o   <= 1'b1;
            end
          end

          START: begin
            if (tick_cnt == TICK_HALF_LAST) begin
              tick_cnt <= '0;
              bit_cnt  <= '0;
              if (!rx_s) begin
                state <= DATA;
              end else begin
                // Too short to be a start bit: drop silently.
                state  <= IDLE;
                busy_o <= 1'b0;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end

          DATA: begin
            if (bit_end) begin
              tick_cnt <= '0;
              shift    <= {rx_s, shift[DATA_BITS-1:1]};
              if (bit_cnt == BIT_LAST) begin
                bit_cnt <= '0;
`ifdef UART_RX_PARITY_EN
                state   <= PARITY;
`else
                state   <= STOP;
`endif
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end

`ifdef UART_RX_PARITY_EN
          PARITY: begin
            if (bit_end) begin
              tick_cnt <= '0;
              par_bit  <= rx_s;
              state    <= STOP;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
`endif

          STOP: begin
            if (bit_end) begin
              tick_cnt    <= '0;
              data_o      <= shift;
              frame_err_o <= !rx_s;
              valid_o     <= 1'b1;
              // Overwrite of a held word is only an overrun if it was not taken this cycle.
              overrun_o   <= valid_o && !ready_i;
`ifdef UART_RX_PARITY_EN
              parity_err_o <= ((^shift) ^ par_bit) != 1'(PARITY_ODD);
`endif
              if (rx_s) begin
                state  <= IDLE;
                busy_o <= 1'b0;
              end else begin
                // Line held low (break): wait for idle before re-arming.
                state <= BREAK_WAIT;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end

          BREAK_WAIT: begin
            if (rx_s) begin
              state  <= IDLE;
              busy_o <= 1'b0;
            end
          end

          default: begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Purpose: directed checks of uart_rx_deserializer with DATA_BITS=8, OVERSAMPLE=16, os_tick every clk.
// Latency: frames are driven bit by bit, 16 clk per bit; outputs sampled on the falling edge.
// Backpressure: exercises ready_i held low (overrun) and single-cycle accept.
module tb_uart_rx_deserializer;

  localparam int OS = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       os_tick;
  logic       rx_i;
  logic       ready_i;
  logic [7:0] data_o;
  logic       valid_o;
  logic       frame_err_o;
  logic       parity_err_o;
  logic       overrun_o;
  logic       busy_o;

  int tests = 0;
  int fails = 0;

  int valid_cnt = 0;
  int ovr_cnt   = 0;
  int busy_cnt  = 0;

  uart_rx_deserializer #(
    .DATA_BITS (8),
    .OVERSAMPLE(OS),
    .PARITY_ODD(0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .os_tick     (os_tick),
    .rx_i        (rx_i),
    .ready_i     (ready_i),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .frame_err_o (frame_err_o),
    .parity_err_o(parity_err_o),
    .overrun_o   (overrun_o),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;

  // Event monitor: counts valid cycles, overrun pulses and busy cycles.
  always @(negedge clk) begin
    if (valid_o)   valid_cnt = valid_cnt + 1;
    if (overrun_o) ovr_cnt   = ovr_cnt + 1;
    if (busy_o)    busy_cnt  = busy_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests = tests + 1;
    if (got !== exp) begin
      fails = fails + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic line_bit(input logic b);
    rx_i = b;
    clks(OS);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b,
                            input logic with_par, input logic par_b);
    line_bit(1'b0);
    for (int i = 0; i < 8; i++) line_bit(d[i]);
    if (with_par) line_bit(par_b);
    line_bit(stop_b);
  endtask

  task automatic sample_point();
    @(negedge clk);
  endtask

  int v0, o0, b0;

  initial begin
    rst     = 1'b1;
    os_tick = 1'b1;
    rx_i    = 1'b1;
    ready_i = 1'b1;
    clks(3);
    sample_point();
    check("rst_data",   32'(data_o),       32'h0);
    check("rst_valid",  32'(valid_o),      32'h0);
    check("rst_ferr",   32'(frame_err_o),  32'h0);
    check("rst_perr",   32'(parity_err_o), 32'h0);
    check("rst_ovr",    32'(overrun_o),    32'h0);
    check("rst_busy",   32'(busy_o),       32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    clks(4);

    // 0xA5, good stop, consumer always ready.
    v0 = valid_cnt; o0 = ovr_cnt;
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
    clks(4);
    sample_point();
    check("a5_valid_cycles", 32'(valid_cnt - v0), 32'd1);
    check("a5_data",         32'(data_o),         32'hA5);
    check("a5_ferr",         32'(frame_err_o),    32'h0);
    check("a5_ovr",          32'(ovr_cnt - o0),   32'd0);
    check("a5_busy",         32'(busy_o),         32'h0);

    // 4-clk glitch: rejected at start-bit centre.
    @(posedge clk); #1;
    v0 = valid_cnt; b0 = busy_cnt;
    rx_i = 1'b0;
    clks(4);
    rx_i = 1'b1;
    clks(40);
    sample_point();
    check("glitch_no_valid", 32'(valid_cnt - v0),                      32'd0);
    check("glitch_busy_seen", 32'(busy_cnt - b0 > 0),                  32'd1);
    check("glitch_busy_bound", 32'(busy_cnt - b0 <= 10),               32'd1);
    check("glitch_busy_end", 32'(busy_o),                              32'h0);

    // 0x3C with stop bit 0 and the line held low 40 clk from the stop bit.
    @(posedge clk); #1;
    v0 = valid_cnt;
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    rx_i = 1'b0;
    clks(40 - OS);
    sample_point();
    check("brk_busy_held", 32'(busy_o), 32'h1);
    @(posedge clk); #1;
    rx_i = 1'b1;
    clks(30);
    sample_point();
    check("brk_valid_cycles", 32'(valid_cnt - v0), 32'd1);
    check("brk_data",         32'(data_o),         32'h3C);
    check("brk_ferr",         32'(frame_err_o),    32'h1);
    check("brk_busy_end",     32'(busy_o),         32'h0);

    // Back-to-back 0x11, 0x22 with consumer stalled.
    @(posedge clk); #1;
    ready_i = 1'b0;
    o0 = ovr_cnt;
    send_frame(8'h11, 1'b1, 1'b0, 1'b0);
    sample_point();
    check("ovr_first_none", 32'(ovr_cnt - o0), 32'd0);
    @(posedge clk); #1;
    send_frame(8'h22, 1'b1, 1'b0, 1'b0);
    sample_point();
    check("ovr_pulses", 32'(ovr_cnt - o0), 32'd1);
    check("ovr_data",   32'(data_o),       32'h22);
    check("ovr_valid",  32'(valid_o),      32'h1);
    @(posedge clk); #1;
    ready_i = 1'b1;
    @(posedge clk); #1;
    sample_point();
    check("ovr_accept_clears", 32'(valid_o), 32'h0);

    // Reset after the 4th data bit of 0xFF, then a clean 0x5A.
    @(posedge clk); #1;
    line_bit(1'b0);
    for (int i = 0; i < 4; i++) line_bit(1'b1);
    rst = 1'b1;
    sample_point();
    check("mid_rst_data",  32'(data_o),    32'h0);
    check("mid_rst_valid", 32'(valid_o),   32'h0);
    check("mid_rst_busy",  32'(busy_o),    32'h0);
    check("mid_rst_ferr",  32'(frame_err_o), 32'h0);
    check("mid_rst_ovr",   32'(overrun_o), 32'h0);
    clks(3);
    rst = 1'b0;
    clks(4);
    v0 = valid_cnt; o0 = ovr_cnt;
    send_frame(8'h5A, 1'b1, 1'b0, 1'b0);
    clks(4);
    sample_point();
    check("post_rst_valid", 32'(valid_cnt - v0), 32'd1);
    check("post_rst_data",  32'(data_o),         32'h5A);
    check("post_rst_ferr",  32'(frame_err_o),    32'h0);
    check("post_rst_perr",  32'(parity_err_o),   32'h0);
    check("post_rst_ovr",   32'(ovr_cnt - o0),   32'd0);

`ifdef UART_RX_PARITY_EN
    // Even parity: 0x07 has three ones, so parity bit 1 is correct.
    @(posedge clk); #1;
    send_frame(8'h07, 1'b1, 1'b1, 1'b1);
    clks(4);
    sample_point();
    check("par_ok_data", 32'(data_o),       32'h07);
    check("par_ok_perr", 32'(parity_err_o), 32'h0);
    @(posedge clk); #1;
    send_frame(8'h07, 1'b1, 1'b1, 1'b0);
    clks(4);
    sample_point();
    check("par_bad_perr", 32'(parity_err_o), 32'h1);
    check("par_bad_ferr", 32'(frame_err_o),  32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
